// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential signed 16/8 restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int N_W_DEF = 16;
  localparam int D_W_DEF = 8;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract.
module div_restore_step
  import seq_div_pkg::*;
#(
  parameter int D_W = D_W_DEF
) (
  input  logic [D_W:0]   prem,
  input  logic           q_msb,
  input  logic [D_W-1:0] dabs,
  output logic [D_W:0]   prem_next,
  output logic           q_bit
);

  logic [D_W+1:0] shifted;
  logic [D_W+1:0] trial;

  always_comb begin
    shifted   = {prem, q_msb};
    trial     = shifted - {2'b00, dabs};
    q_bit     = ~trial[D_W+1];
    prem_next = q_bit ? trial[D_W:0] : shifted[D_W:0];
  end

endmodule

// File: rtl/seq_div_16by8.sv
// Sequential signed radix-2 restoring divider with start/rdy handshake.
//   state | meaning
//   IDLE  | waiting for start; result outputs held
//   CALC  | one quotient bit per cycle on magnitudes
//   FIX   | apply signs / special-case results, raise rdy
module seq_div_16by8
  import seq_div_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int D_W = D_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic [N_W-1:0] quot,
  output logic [D_W-1:0] rem,
  output logic           busy,
  output logic           rdy,
  output logic           dz,
  output logic           ovf
);

  localparam int CW = cnt_w(N_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_W - 1);
  localparam logic [N_W-1:0] MOST_NEG = {1'b1, {(N_W-1){1'b0}}};

  state_t         state;
  logic [N_W-1:0] qreg;
  logic [D_W-1:0] dabs;
  logic [D_W-1:0] rem_dz;
  logic [D_W:0]   prem;
  logic [D_W:0]   prem_nxt;
  logic           qbit;
  logic [CW-1:0]  cnt;
  logic           sign_q, sign_r, spec_dz, spec_ovf;

  logic [N_W-1:0] a_abs;
  logic [D_W-1:0] b_abs;
  logic           is_dz, is_ovf;

  always_comb begin
    a_abs  = dividend[N_W-1] ? -dividend : dividend;
    b_abs  = divisor[D_W-1] ? -divisor : divisor;
    is_dz  = (divisor == '0);
    is_ovf = (dividend == MOST_NEG) && (divisor == '1);
  end

  div_restore_step #(.D_W(D_W)) u_step (
    .prem      (prem),
    .q_msb     (qreg[N_W-1]),
    .dabs      (dabs),
    .prem_next (prem_nxt),
    .q_bit     (qbit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      qreg     <= '0;
      dabs     <= '0;
      rem_dz   <= '0;
      prem     <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      spec_dz  <= 1'b0;
      spec_ovf <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      rdy      <= 1'b0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            qreg     <= a_abs;
            dabs     <= b_abs;
            rem_dz   <= dividend[D_W-1:0];
            sign_q   <= dividend[N_W-1] ^ divisor[D_W-1];
            sign_r   <= dividend[N_W-1];
            spec_dz  <= is_dz;
            spec_ovf <= is_ovf;
            prem     <= '0;
            cnt      <= '0;
            rdy      <= 1'b0;
            dz       <= 1'b0;
            ovf      <= 1'b0;
            busy     <= 1'b1;
            state    <= (is_dz || is_ovf) ? FIX : CALC;
          end
        end
        CALC: begin
          prem <= prem_nxt;
          qreg <= {qreg[N_W-2:0], qbit};
          cnt  <= cnt + CW'(1);
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          busy  <= 1'b0;
          rdy   <= 1'b1;
          dz    <= spec_dz;
          ovf   <= spec_ovf;
          state <= IDLE;
          // divide-by-zero wins; it can never coincide with overflow anyway
          if (spec_dz) begin
            quot <= '1;
            rem  <= rem_dz;
          end else if (spec_ovf) begin
            quot <= MOST_NEG;
            rem  <= '0;
          end else begin
            quot <= sign_q ? -qreg : qreg;
            rem  <= sign_r ? -prem[D_W-1:0] : prem[D_W-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_div_16by8.md
Name: seq_div_16by8

Overview:
- Sequential radix-2 restoring divider for signed two's-complement operands: 16-bit dividend divided by 8-bit divisor, giving a 16-bit quotient and an 8-bit remainder.
- It is the inverse companion of the team's sequential 8-bit multiplier and sits beside it in the arithmetic cluster.
- Uses a start/rdy handshake and takes one quotient bit per cycle.
- Flags divide-by-zero and the single signed-overflow case.

Parameters:
- N_W, 16, dividend and quotient width.
- D_W, 8, divisor and remainder width. Constraint: N_W >= D_W.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  N_W  signed dividend; latched when start is accepted.
- divisor  input  D_W  signed divisor; latched when start is accepted.
- quot  output  N_W  signed quotient; registered.
- rem  output  D_W  signed remainder; registered.
- busy  output  1  high while in CALC or FIX.
- rdy  output  1  result valid; level, held until the next accepted start.
- dz  output  1  divide-by-zero flag; valid while rdy=1.
- ovf  output  1  overflow flag; valid while rdy=1.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; quot=0, rem=0, busy=0, rdy=0, dz=0, ovf=0.
  - Internal registers cleared; any in-progress division is abandoned and no result is produced.
- States: IDLE, CALC, FIX. The state encoding is held in the shared package.
- IDLE with start=1 at edge E0:
  - Latch |dividend| into the quotient shift register and |divisor| into the divisor register.
  - Latch sign_q = dividend[msb] ^ divisor[msb] and sign_r = dividend[msb].
  - Clear the partial remainder (D_W+1 bits) and set count=0.
  - Clear rdy, dz and ovf; set busy=1.
  - If divisor==0, or (dividend==most-negative and divisor==-1), set the special flag and go to FIX. Otherwise go to CALC.
- IDLE with start=0: hold all outputs.
- CALC, one iteration per edge, edges E1..E_N_W:
  - Shift {prem, qreg} left by 1.
  - Trial = prem - |divisor|, with |divisor| zero-extended to D_W+1 bits.
  - If trial >= 0: prem <= trial and qreg[0] <= 1. Otherwise keep prem and set qreg[0] <= 0.
  - count increments. After iteration N_W (count==N_W-1 at the edge), go to FIX.
- FIX, one edge, then go to IDLE:
  - quot = sign_q ? -qreg : qreg. rem = sign_r ? -prem[D_W-1:0] : prem[D_W-1:0].
  - Rounding is truncation toward zero; the remainder takes the sign of the dividend; |rem| < |divisor|.
  - busy <= 0, rdy <= 1.
  - Divide-by-zero: quot = all ones (-1), rem = dividend[D_W-1:0], dz=1.
  - Overflow: quot = most-negative (0x8000), rem = 0, ovf=1.
- Latency:
  - Normal case: rdy rises at edge E(N_W+1), i.e. 17 cycles after the accepting edge at defaults.
  - Special cases: rdy rises at E1.
- start while busy: ignored, no queueing, operands unchanged.
- start while rdy=1 (in IDLE): accepted; rdy drops at that edge, and quot/rem keep their old values until FIX.
- Operand inputs may change freely after the accepting edge.
- The -128 divisor magnitude (128) fits in D_W+1 bits; the partial remainder is never truncated during CALC.

Decomposition:
- Package seq_div_pkg contains:
  - the state enum (IDLE, CALC, FIX);
  - constants N_W_DEF=16 and D_W_DEF=8;
  - a count-width function (clog2 of N_W).
- One combinational sub-module, div_restore_step:
  - inputs prem, qreg msb, |divisor|;
  - outputs the next prem and the quotient bit.
- The top level holds the FSM, the operand/sign registers and the FIX-stage negation.

Test Plan:
- 1000 / 7, start pulsed one cycle -> after 17 cycles rdy=1, quot=142 (0x008E), rem=6 (0x06), dz=0, ovf=0; busy high for exactly 17 cycles.
- -1000 / 7 -> quot=0xFF72 (-142), rem=0xFA (-6); 100 / -3 -> quot=0xFFDF (-33), rem=0x01; -32768 / -128 -> quot=0x0100, rem=0x00.
- 0x1234 / 0 -> rdy one cycle after accept, dz=1, quot=0xFFFF, rem=0x34. Then -32768 / -1 -> rdy after 1 cycle, ovf=1, dz=0, quot=0x8000, rem=0x00.
- start re-pulsed at cycles 3 and 10 of a 1000/7 operation with different operands -> ignored; the result is still 142 r 6. A new start while rdy=1 (500/9) -> rdy drops that edge; 17 cycles later quot=55, rem=5.
- reset asserted asynchronously at cycle 8 of an operation -> all outputs 0 immediately, state IDLE. A fresh 255/16 after deassert -> quot=15, rem=15, normal latency.
